conv3x3_pool_pe: RTL and testbench
==================================

Name: conv3x3_pool_pe

Overview:
- Parametrised successor of the fixed 8-bit 3x3 MAC/pool datapath.
- Takes one 4x4 activation window and one 3x3 kernel per beat, and computes the four stride-1 3x3 convolution outputs.
- Accumulates these across a run of input-channel beats delimited by last_i, then applies ReLU, shift-descale and saturation, followed by 2x2 max-pooling.
- Sits between the window parser and the output line buffer. Emits one pooled pixel per completed channel run, with a fixed pipeline latency.

Parameters:
- DW, 8, activation width, unsigned.
- WW, 8, weight width, two's-complement signed.
- ACCW, 32, accumulator width, signed.
- SHIFT, 7, descale right-shift amount (divide by 2^SHIFT); legal range 1..ACCW-2.
- OW, 8, output width, unsigned.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- vld_i  in  1  input beat valid.
- last_i  in  1  marks the final channel beat of the current run; qualified by vld_i.
- din_i  in  16*DW  4x4 window, row-major; p(r,c) = din_i[(4r+c)*DW +: DW].
- wgt_i  in  9*WW  3x3 kernel, row-major; k(r,c) = wgt_i[(3r+c)*WW +: WW].
- vld_o  out  1  one-cycle pulse, pooled result valid.
- dout_o  out  OW  pooled result.
- busy_o  out  1  high while a channel run is partially accumulated (at least one beat taken, last not yet taken).

Behaviour:
- Reset:
  - rstn is asynchronous, active-low; clock is clk, rising edge.
  - On reset: vld_o=0, dout_o=0, busy_o=0, all pipeline valids cleared, all four accumulators cleared, internal "fresh" flag set to 1.
- Convolution definition: o(i,j) = sum over r,c in 0..2 of p(i+r, j+c) * k(r,c), for i,j in {0,1}.
  - Product width is DW+WW+1, signed; p is zero-extended before multiplying.
  - 9-term sum is sign-extended to ACCW.
- Pipeline (no stall; a beat is accepted on every edge where vld_i=1):
  - S1: register all 36 products plus a valid/last tag.
  - S2: register the four 9-term sums plus tag.
  - S3: accumulators. For each of the four: acc <= (fresh ? 0 : acc) + sum. After each update, fresh <= last.
  - S4: per output, compute ReLU then descale then saturate: a = acc<0 ? 0 : acc; q = a >> SHIFT; y = q > 2^OW-1 ? 2^OW-1 : q[OW-1:0]. Then dout_o <= max(y00, y01, y10, y11) and vld_o <= 1. S4 fires only when the S3 beat carried last.
- Latency:
  - A beat with vld_i=1 and last_i=1 sampled at edge T produces vld_o=1 and dout_o valid in the cycle after edge T+4.
  - vld_o is high for exactly one cycle.
  - dout_o holds its value until the next result.
- Back-to-back runs: a last beat followed immediately by a new beat starts a fresh accumulation with no bubble. Gaps (vld_i=0) anywhere are allowed and leave all state unchanged.
- Single-beat run (first beat has last_i=1) is legal.
- last_i while vld_i=0 is ignored.
- busy_o: set when a non-last beat enters S3; cleared when a last beat enters S3.
- Accumulator overflow wraps modulo 2^ACCW, with no flag; sizing ACCW is the integrator's responsibility.
- Reset asserted mid-run discards every in-flight beat and the partial accumulation. No vld_o is produced for the discarded run.

Optional Feature:
- Macro: CONV_POOL_ROUND_EN.
- Defined: S4 uses q = (a + 2^(SHIFT-1)) >> SHIFT, i.e. round-half-up. The addition is done at ACCW+1 bits so it cannot wrap.
- Undefined: truncating shift exactly as described under Behaviour. Adds no hardware.

Test Plan:
- Single run, all p=16, all k=8, last on the first beat: each o=1152; vld_o pulses 4 cycles after the input edge; dout_o=9. busy_o stays 0.
- Three-beat run, each beat p=16, k=8, last on beat 3, with one idle cycle between beats 1 and 2: acc=3456, dout_o=27. busy_o is 1 from beat 1 until beat 3 reaches S3. Exactly one vld_o.
- Saturation and ReLU:
  - p=255, k=127: dout_o=255.
  - Next run, p=255, k=-1 (all 1s pattern): all o negative, dout_o=0.
  - Both runs issued back-to-back: vld_o pulses on consecutive cycles.
- Pooling select: p(3,3)=255, all other p=0, k(2,2)=64, all other k=0. Then o11=16320 and the other three outputs are 0, so dout_o=127.
- Rounding: p=16, k(0,0)=12, all other k=0, o=192 → dout_o=1 without CONV_POOL_ROUND_EN, 2 with it.
- Reset mid-run: issue 2 non-last beats, pulse rstn low for 1 cycle, then a single last beat with p=16, k=8. Required: no vld_o before that beat, then dout_o=9 (old partial accumulation discarded).

Source files
------------

// File: rtl/conv3x3_pool_pe.sv
// 3x3 convolution over a 4x4 window with channel accumulation, ReLU/descale/saturate and 2x2 max-pool.
// Optional round-half-up descale is enabled by defining CONV_POOL_ROUND_EN.
module conv3x3_pool_pe #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int ACCW  = 32,
    parameter int SHIFT = 7,
    parameter int OW    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             vld_i,
    input  logic             last_i,
    input  logic [16*DW-1:0] din_i,
    input  logic [9*WW-1:0]  wgt_i,
    output logic             vld_o,
    output logic [OW-1:0]    dout_o,
    output logic             busy_o
);

    localparam int PW = DW + WW + 1;
    localparam int SW = PW + 4;
    localparam logic [ACCW:0] QMAX = {{(ACCW + 1 - OW){1'b0}}, {OW{1'b1}}};
`ifdef CONV_POOL_ROUND_EN
    localparam logic [ACCW:0] RND = (ACCW + 1)'(1) << (SHIFT - 1);
`endif

    logic                   r_s1_vld, r_s1_last, r_s2_vld, r_s2_last;
    logic                   r_s3_last, r_s4_vld, r_fresh;
    logic signed [PW-1:0]   r_prod [4][9];
    logic signed [SW-1:0]   w_sum  [4];
    logic signed [SW-1:0]   r_sum  [4];
    logic signed [ACCW-1:0] r_acc  [4];
    logic [ACCW:0]          w_a    [4];
    logic [ACCW:0]          w_q    [4];
    logic [OW-1:0]          w_y    [4];
    logic [OW-1:0]          r_y    [4];
    logic [OW-1:0]          w_max;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
        end else begin
            r_s1_vld  <= vld_i;
            r_s1_last <= vld_i & last_i;
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
        end
    end

    // S1: output n=(2i+j), tap t=(3r+c) multiplies p(i+r, j+c) by k(r,c)
    always_ff @(posedge clk) begin
        if (vld_i) begin
            for (int unsigned n = 0; n < 4; n++) begin
                for (int unsigned t = 0; t < 9; t++) begin
                    r_prod[n][t] <=
                        PW'($signed({1'b0, din_i[(4 * (n / 2 + t / 3) + n % 2 + t % 3) * DW +: DW]}))
                        * PW'($signed(wgt_i[t * WW +: WW]));
                end
            end
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            w_sum[n] = '0;
            for (int unsigned t = 0; t < 9; t++) begin
                w_sum[n] = w_sum[n] + SW'(r_prod[n][t]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_vld) begin
            for (int unsigned n = 0; n < 4; n++) begin
                r_sum[n] <= w_sum[n];
            end
        end
    end

    // S3: a fresh accumulator discards the previous run instead of being cleared separately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned n = 0; n < 4; n++) begin
                r_acc[n] <= '0;
            end
            r_fresh   <= 1'b1;
            busy_o    <= 1'b0;
            r_s3_last <= 1'b0;
        end else begin
            r_s3_last <= r_s2_vld & r_s2_last;
            if (r_s2_vld) begin
                for (int unsigned n = 0; n < 4; n++) begin
                    r_acc[n] <= (r_fresh ? '0 : r_acc[n]) + ACCW'(r_sum[n]);
                end
                r_fresh <= r_s2_last;
                busy_o  <= ~r_s2_last;
            end
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            w_a[n] = r_acc[n][ACCW-1] ? '0 : {1'b0, r_acc[n]};
`ifdef CONV_POOL_ROUND_EN
            w_q[n] = (w_a[n] + RND) >> SHIFT;
`else
            w_q[n] = w_a[n] >> SHIFT;
`endif
            w_y[n] = (w_q[n] > QMAX) ? '1 : w_q[n][OW-1:0];
        end
    end

    always_comb begin
        w_max = r_y[0];
        for (int unsigned n = 1; n < 4; n++) begin
            if (r_y[n] > w_max) w_max = r_y[n];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned n = 0; n < 4; n++) begin
                r_y[n] <= '0;
            end
            r_s4_vld <= 1'b0;
            vld_o    <= 1'b0;
            dout_o   <= '0;
        end else begin
            r_s4_vld <= r_s3_last;
            if (r_s3_last) begin
                for (int unsigned n = 0; n < 4; n++) begin
                    r_y[n] <= w_y[n];
                end
            end
            vld_o <= r_s4_vld;
            if (r_s4_vld) dout_o <= w_max;
        end
    end

endmodule

// File: tb/tb_conv3x3_pool_pe.sv
// Scoreboard bench for conv3x3_pool_pe: random and directed channel runs against a behavioural model.
module tb_conv3x3_pool_pe;

    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int ACCW  = 32;
    localparam int SHIFT = 7;
    localparam int OW    = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         vld_i = 1'b0;
    logic         last_i = 1'b0;
    logic [127:0] din_i = '0;
    logic [71:0]  wgt_i = '0;
    logic         vld_o;
    logic [7:0]   dout_o;
    logic         busy_o;

    conv3x3_pool_pe #(
        .DW(DW), .WW(WW), .ACCW(ACCW), .SHIFT(SHIFT), .OW(OW)
    ) dut (
        .clk(clk), .rstn(rstn), .vld_i(vld_i), .last_i(last_i),
        .din_i(din_i), .wgt_i(wgt_i),
        .vld_o(vld_o), .dout_o(dout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    int m_acc[4];
    bit m_fresh = 1'b1;

    // run-in-progress status as of each sampled beat; busy_o shows it two edges later
    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st0 <= 1'b0; st1 <= 1'b0; st2 <= 1'b0;
        end else begin
            if (vld_i) st0 <= ~last_i;
            st1 <= st0;
            st2 <= st1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            n_cmp++;
            if (vld_o !== 1'b0 || dout_o !== 8'd0 || busy_o !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state: vld_o=%0b dout_o=%0d busy_o=%0b, required 0/0/0",
                         vld_o, dout_o, busy_o);
            end
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                e = sb.pop_front();
                $display("FAIL missing_out: no vld_o at cycle %0d, required dout_o=%0d", e.cyc, e.val);
            end
            if (vld_o) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_vld: vld_o=1 dout_o=%0d at cycle %0d, required no output",
                             dout_o, cyc);
                end else if (sb[0].cyc != cyc) begin
                    n_bad++;
                    $display("FAIL latency: vld_o at cycle %0d, required cycle %0d", cyc, sb[0].cyc);
                end else begin
                    e = sb.pop_front();
                    if (dout_o !== e.val) begin
                        n_bad++;
                        $display("FAIL dout: got %0d, required %0d (cycle %0d)", dout_o, e.val, cyc);
                    end
                end
            end
            n_cmp++;
            if (busy_o !== st2) begin
                n_bad++;
                $display("FAIL busy: got %0b, required %0b (cycle %0d)", busy_o, st2, cyc);
            end
        end
    end

    function automatic logic [127:0] fill_p(input logic [7:0] v);
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    function automatic logic [71:0] fill_k(input logic [7:0] v);
        logic [71:0] f;
        for (int i = 0; i < 9; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    task automatic model_beat(input logic [127:0] d, input logic [71:0] w, input bit last);
        int     p[4][4];
        int     k[3][3];
        int     s;
        longint a, q, y, mx;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) p[r][c] = int'(d[(4*r + c)*8 +: 8]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) k[r][c] = int'($signed(w[(3*r + c)*8 +: 8]));
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) s += p[i+r][j+c] * k[r][c];
                if (m_fresh) m_acc[2*i + j] = 0;
                m_acc[2*i + j] += s;
            end
        end
        m_fresh = last;
        if (last) begin
            mx = 0;
            for (int n = 0; n < 4; n++) begin
                a = (m_acc[n] < 0) ? 0 : longint'(m_acc[n]);
`ifdef CONV_POOL_ROUND_EN
                a = a + (longint'(1) << (SHIFT - 1));
`endif
                q = a >> SHIFT;
                y = (q > 255) ? 255 : q;
                if (y > mx) mx = y;
            end
            sb.push_back('{val: 8'(mx), cyc: cyc + 5});
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [71:0] w, input bit last);
        vld_i  = 1'b1;
        last_i = last;
        din_i  = d;
        wgt_i  = w;
        model_beat(d, w, last);
        @(posedge clk);
        #1;
        vld_i  = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            vld_i  = 1'b0;
            last_i = 1'($urandom_range(0, 1));
            din_i  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        last_i = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [71:0]  w;
        int           len;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        send(fill_p(8'd16), fill_k(8'd8), 1'b1);
        idle(6);

        send(fill_p(8'd16), fill_k(8'd8), 1'b0);
        idle(1);
        send(fill_p(8'd16), fill_k(8'd8), 1'b0);
        send(fill_p(8'd16), fill_k(8'd8), 1'b1);
        idle(6);

        send(fill_p(8'd255), fill_k(8'd127), 1'b1);
        send(fill_p(8'd255), fill_k(8'hFF), 1'b1);
        idle(6);

        d = '0;
        d[15*8 +: 8] = 8'd255;
        w = '0;
        w[8*8 +: 8] = 8'd64;
        send(d, w, 1'b1);
        idle(6);

        w = '0;
        w[7:0] = 8'd12;
        send(fill_p(8'd16), w, 1'b1);
        idle(6);

        for (int r = 0; r < 60; r++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < 16; i++)
                    d[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                               : 8'($urandom_range(0, 40));
                for (int i = 0; i < 9; i++)
                    w[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                               : 8'(int'($urandom_range(0, 31)) - 16);
                send(d, w, b == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(8);

        send(fill_p(8'd16), fill_k(8'd8), 1'b0);
        send(fill_p(8'd16), fill_k(8'd8), 1'b0);
        rstn    = 1'b0;
        m_fresh = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        send(fill_p(8'd16), fill_k(8'd8), 1'b1);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
